os_output_collector: RTL

OS_OUTPUT_COLLECTOR -- requirements
Module: os_output_collector

---
 rtl/os_collect_pkg.sv | 29 ++
 rtl/os_col_counter.sv | 57 +++++
 rtl/os_output_collector.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/os_collect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : os_collect_pkg
// Purpose  : Shared definitions for the output-stationary output collector:
//            collector state encoding and index/counter width helpers.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package os_collect_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   // Width of an index into n items (never narrower than one bit).
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Width of a per-column counter that must be able to hold the value n.
   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage : os_collect_pkg
`default_nettype wire

// File: rtl/os_col_counter.sv
`default_nettype none
// ============================================================================
// Module   : os_col_counter
// Purpose  : Per-column strobe counter for the output collector. The k-th
//            strobe of a tile targets row ROWS-1-k; the counter saturates at
//            ROWS and flags any further strobe as an overflow.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            clear           - restart counting (tile start)
//            strobe          - column output strobe, already qualified
//            target_row      - row addressed by the current strobe
//            full_next       - counter will equal ROWS after this cycle
//            overflow        - strobe arrived with counter already at ROWS
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module os_col_counter
   import os_collect_pkg::*;
#(
   parameter int ROWS  = 4,
   parameter int CNT_W = cnt_w(ROWS),
   parameter int ROW_W = idx_w(ROWS)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             strobe,
   output logic [ROW_W-1:0] target_row,
   output logic             full_next,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(ROWS);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ROWS - 1);

   logic [CNT_W-1:0] count;
   logic             full;
   logic             advance;

   assign full       = (count == C_FULL);
   assign advance    = strobe & ~full;
   assign overflow   = strobe & full;
   // Rows fill bottom-up: first strobe lands in the last row.
   assign target_row = ROW_W'(ROWS - 1 - int'(count));
   assign full_next  = full | (advance & (count == C_LAST));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (advance) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule : os_col_counter
`default_nettype wire

// File: rtl/os_output_collector.sv
`default_nettype none
// ============================================================================
// Module   : os_output_collector
// Purpose  : Assembles one ROWS x COLS output tile from the bottom outputs of
//            a systolic array, skipping faulty PEs and filling their entries
//            from redundant recompute units (RUs). Presents the finished tile
//            with a valid/ready handshake.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            start             - begin collecting a tile (IDLE only)
//            stw_result_mat    - per-PE health, 1 = healthy
//            fsm_output        - array bottom outputs, one word per column
//            output_col_valid  - per-column output strobe
//            ru_output_valid   - per-RU result strobe
//            ru_bottom_out     - RU result words
//            ru_row_mapping    - target row per RU
//            ru_col_mapping    - target column per RU
//            output_matrix     - assembled tile, entry (r,c) at word r*COLS+c
//            matrix_valid      - tile complete, held until matrix_ready
//            matrix_ready      - consumer accepts tile
//            busy              - high while collecting or holding a tile
//            collect_err       - sticky protocol error flag
// Config   : OS_COLLECT_ERR_CHECK_EN - enables collect_err detection;
//            when undefined collect_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module os_output_collector
   import os_collect_pkg::*;
#(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int WORD_SIZE = 16,
   parameter int NUM_RU    = 4
)(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [ROWS*COLS-1:0]              stw_result_mat,
   input  logic [COLS*WORD_SIZE-1:0]         fsm_output,
   input  logic [COLS-1:0]                   output_col_valid,
   input  logic [NUM_RU-1:0]                 ru_output_valid,
   input  logic [NUM_RU*WORD_SIZE-1:0]       ru_bottom_out,
   input  logic [NUM_RU*idx_w(ROWS)-1:0]     ru_row_mapping,
   input  logic [NUM_RU*idx_w(COLS)-1:0]     ru_col_mapping,
   output logic [ROWS*COLS*WORD_SIZE-1:0]    output_matrix,
   output logic                              matrix_valid,
   input  logic                              matrix_ready,
   output logic                              busy,
   output logic                              collect_err
);

   localparam int RW = idx_w(ROWS);
   localparam int CW = idx_w(COLS);
   localparam int NE = ROWS * COLS;

   state_t            state;
   logic [NE-1:0]     pending;
   logic [NE-1:0]     pending_clr;
   logic [NE-1:0]     pending_next;
   logic              in_collect;
   logic              tile_start;
   logic              done_next;

   logic [COLS-1:0]    col_full_next;
   logic [COLS-1:0]    col_over;
   logic [COLS-1:0]    col_strobe;
   logic [COLS*RW-1:0] col_target;
   logic [COLS-1:0]    col_we;
   int                 col_idx [COLS];

   logic [NUM_RU-1:0]  ru_in_range;
   logic [NUM_RU-1:0]  ru_we;
   int                 ru_idx [NUM_RU];

   assign in_collect = (state == ST_COLLECT);
   assign tile_start = (state == ST_IDLE) && start;
   // Strobes outside COLLECT never reach the counters, so they neither
   // write nor count.
   assign col_strobe = output_col_valid & {COLS{in_collect}};

   genvar gc;
   generate
      for (gc = 0; gc < COLS; gc++) begin : g_col
         os_col_counter #(
            .ROWS  (ROWS),
            .CNT_W (cnt_w(ROWS)),
            .ROW_W (RW)
         ) u_col_counter (
            .clk        (clk),
            .rst        (rst),
            .clear      (tile_start),
            .strobe     (col_strobe[gc]),
            .target_row (col_target[gc*RW +: RW]),
            .full_next  (col_full_next[gc]),
            .overflow   (col_over[gc])
         );
      end
   endgenerate

   // Write decode for array columns and RUs, plus completion look-ahead so
   // matrix_valid registers on the same edge as the final write.
   always_comb begin
      pending_clr = '0;
      for (int i = 0; i < NUM_RU; i++) begin
         ru_in_range[i] = (int'(ru_row_mapping[i*RW +: RW]) < ROWS) &&
                          (int'(ru_col_mapping[i*CW +: CW]) < COLS);
         ru_idx[i]      = ru_in_range[i] ?
                          int'(ru_row_mapping[i*RW +: RW]) * COLS +
                          int'(ru_col_mapping[i*CW +: CW]) : 0;
         ru_we[i]       = in_collect && ru_output_valid[i] && ru_in_range[i];
         if (ru_we[i]) begin
            pending_clr[ru_idx[i]] = 1'b1;
         end
      end
      for (int c = 0; c < COLS; c++) begin
         col_idx[c] = int'(col_target[c*RW +: RW]) * COLS + c;
         col_we[c]  = col_strobe[c] && !col_over[c] && (col_idx[c] < NE) &&
                      stw_result_mat[(col_idx[c] < NE) ? col_idx[c] : 0];
      end
      pending_next = pending & ~pending_clr;
      done_next    = (&col_full_next) && (pending_next == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         pending       <= '0;
         output_matrix <= '0;
         matrix_valid  <= 1'b0;
         busy          <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_COLLECT;
                  pending <= ~stw_result_mat;
                  busy    <= 1'b1;
               end
            end
            ST_COLLECT: begin
               for (int c = 0; c < COLS; c++) begin
                  if (col_we[c]) begin
                     output_matrix[col_idx[c]*WORD_SIZE +: WORD_SIZE] <=
                        fsm_output[c*WORD_SIZE +: WORD_SIZE];
                  end
               end
               // Issued after the array writes so an RU wins a same-entry
               // collision.
               for (int i = 0; i < NUM_RU; i++) begin
                  if (ru_we[i]) begin
                     output_matrix[ru_idx[i]*WORD_SIZE +: WORD_SIZE] <=
                        ru_bottom_out[i*WORD_SIZE +: WORD_SIZE];
                  end
               end
               pending <= pending_next;
               if (done_next) begin
                  state        <= ST_DONE;
                  matrix_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (matrix_valid && matrix_ready) begin
                  state        <= ST_IDLE;
                  matrix_valid <= 1'b0;
                  busy         <= 1'b0;
               end
            end
            default: begin
               state        <= ST_IDLE;
               matrix_valid <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

`ifdef OS_COLLECT_ERR_CHECK_EN
   logic err_event;

   always_comb begin
      err_event = |col_over;
      for (int i = 0; i < NUM_RU; i++) begin
         if (in_collect && ru_output_valid[i]) begin
            if (!ru_in_range[i] || stw_result_mat[ru_idx[i]]) begin
               err_event = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         collect_err <= 1'b0;
      end else if (err_event) begin
         collect_err <= 1'b1;
      end
   end
`else
   assign collect_err = 1'b0;
`endif

endmodule : os_output_collector
`default_nettype wire
